// File: rtl/washer_panel.sv
// washer_panel: synchronises and debounces panel inputs, then runs the SETUP/RUN/PAUSED panel FSM
module washer_panel #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_raw,
  input  logic       btn_pause_raw,
  input  logic       btn_mode_raw,
  input  logic       sw_cover_raw,
  input  logic       sw_water_raw,
  input  logic       done,
  output logic       start,
  output logic       pause,
  output logic [1:0] mode,
  output logic       cover_closed,
  output logic       water_connected,
  output logic       run_led,
  output logic       reject,
  output logic [6:0] mode_seg
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  typedef enum logic [1:0] {SETUP, RUN, PAUSED} state_t;
  logic [4:0] w_raw, r_s1, r_s2, r_deb;
  logic [2:0] r_deb_q, r_arm, w_press;
  logic [1:0] r_live, r_mode;
  logic [CW-1:0] r_cnt [5];
  state_t r_state, w_next;
  logic r_start, r_pause, r_run_led, r_reject, w_ok, w_rej;
  assign w_raw = {sw_water_raw, sw_cover_raw, btn_mode_raw, btn_pause_raw, btn_start_raw};
  // a button only counts once it has been seen released after reset, so a held button cannot fire
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_deb <= '0;
      r_deb_q <= '0;
      r_arm <= '0;
      r_live <= '0;
      for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= w_raw;
      r_s2 <= r_s1;
      r_deb_q <= r_deb[2:0];
      r_live <= {r_live[0], 1'b1};
      r_arm <= r_arm | ({3{r_live[1]}} & ~r_s2[2:0]);
      for (int i = 0; i < 5; i++) begin
        if (r_s2[i] == r_deb[i]) r_cnt[i] <= '0;
        else if (r_cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else r_cnt[i] <= r_cnt[i] + CW'(1);
      end
    end
  end
  assign w_press = r_deb[2:0] & ~r_deb_q & r_arm;
  assign w_ok = r_deb[3] & r_deb[4];
  always_comb begin
    w_next = (r_state == SETUP) ? ((w_press[0] && w_ok) ? RUN : SETUP) :
             (r_state == RUN) ? (done ? SETUP : (!w_ok || w_press[1]) ? PAUSED : RUN) :
             (r_state == PAUSED) ? (w_press[1] ? SETUP : (w_press[0] && w_ok) ? RUN : PAUSED) :
             SETUP;
    w_rej = w_press[0] && !w_ok && (r_state == SETUP || (r_state == PAUSED && !w_press[1]));
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= SETUP;
      r_mode <= 2'd0;
      r_start <= 1'b0;
      r_pause <= 1'b0;
      r_run_led <= 1'b0;
      r_reject <= 1'b0;
    end else begin
      r_state <= w_next;
      r_start <= w_next == RUN;
      r_pause <= w_next == PAUSED;
      r_run_led <= w_next == RUN;
      r_reject <= w_rej;
      if (r_state == SETUP && w_next == SETUP && w_press[2])
        r_mode <= (r_mode == 2'd2) ? 2'd0 : r_mode + 2'd1;
    end
  end
  always_comb begin
    mode_seg = (r_mode == 2'd0) ? 7'b1111001 :
               (r_mode == 2'd1) ? 7'b0100100 :
               (r_mode == 2'd2) ? 7'b0110000 : 7'b1111111;
  end
  assign start = r_start;
  assign pause = r_pause;
  assign mode = r_mode;
  assign run_led = r_run_led;
  assign reject = r_reject;
  assign cover_closed = r_deb[3];
  assign water_connected = r_deb[4];
endmodule

// File: tb/tb_washer_panel.sv
// tb_washer_panel: directed and random panel stimulus checked every cycle against a rule-level model
module tb_washer_panel;
  logic clk = 1'b0, reset = 1'b1;
  logic bs = 1'b0, bp = 1'b0, bm = 1'b0, sc = 1'b0, sw = 1'b0, done = 1'b0;
  logic start, pause, cover_closed, water_connected, run_led, reject;
  logic [1:0] mode;
  logic [6:0] mode_seg;
  always #5 clk = ~clk;
  washer_panel #(.DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .btn_start_raw(bs), .btn_pause_raw(bp), .btn_mode_raw(bm),
    .sw_cover_raw(sc), .sw_water_raw(sw), .done(done), .start(start), .pause(pause),
    .mode(mode), .cover_closed(cover_closed), .water_connected(water_connected),
    .run_led(run_led), .reject(reject), .mode_seg(mode_seg)
  );
  int total = 0, bad = 0;
  bit h [5][6];
  bit hv [6];
  bit md [5];
  bit mq [3];
  bit ma [3];
  int mst = 0, mmode = 0;
  bit mrej = 1'b0;
  logic [6:0] seg_tab [3] = '{7'b1111001, 7'b0100100, 7'b0110000};
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  // each input flips once its last four synchronised samples all disagree with it
  task automatic model();
    bit raw [5];
    bit ps, pp, pm, ok;
    raw[0] = bs; raw[1] = bp; raw[2] = bm; raw[3] = sc; raw[4] = sw;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        md[i] = 0;
        for (int j = 0; j < 6; j++) h[i][j] = 0;
      end
      for (int j = 0; j < 6; j++) hv[j] = 0;
      for (int i = 0; i < 3; i++) begin mq[i] = 0; ma[i] = 0; end
      mst = 0; mmode = 0; mrej = 0;
      return;
    end
    ok = md[3] & md[4];
    ps = md[0] & !mq[0] & ma[0];
    pp = md[1] & !mq[1] & ma[1];
    pm = md[2] & !mq[2] & ma[2];
    mrej = 0;
    if (mst == 0) begin
      if (ps && ok) mst = 1;
      else begin
        mrej = ps;
        if (pm) mmode = (mmode + 1) % 3;
      end
    end else if (mst == 1) begin
      if (done) mst = 0;
      else if (!ok || pp) mst = 2;
    end else begin
      if (pp) mst = 0;
      else if (ps) begin
        if (ok) mst = 1;
        else mrej = 1;
      end
    end
    for (int i = 0; i < 3; i++) mq[i] = md[i];
    for (int i = 0; i < 5; i++) begin
      for (int j = 5; j > 0; j--) h[i][j] = h[i][j-1];
      h[i][0] = raw[i];
    end
    for (int j = 5; j > 0; j--) hv[j] = hv[j-1];
    hv[0] = 1;
    for (int i = 0; i < 5; i++)
      if (h[i][2] != md[i] && h[i][3] != md[i] && h[i][4] != md[i] && h[i][5] != md[i]) md[i] = !md[i];
    for (int i = 0; i < 3; i++) if (hv[2] && !h[i][2]) ma[i] = 1;
  endtask
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      model();
      #1;
      chk("start", start, 8'(mst == 1));
      chk("pause", pause, 8'(mst == 2));
      chk("run_led", run_led, 8'(mst == 1));
      chk("reject", reject, 8'(mrej));
      chk("mode", mode, 8'(mmode));
      chk("mode_seg", mode_seg, seg_tab[mmode]);
      chk("cover", cover_closed, 8'(md[3]));
      chk("water", water_connected, 8'(md[4]));
    end
  endtask
  task automatic press(input int which);
    bs = (which == 0 || which == 3); bp = (which == 1 || which == 3); bm = (which == 2);
    cyc(8);
    bs = 0; bp = 0; bm = 0;
    cyc(8);
  endtask
  initial begin
    int lat, rc;
    cyc(3);
    chk("rst_start", start, 0);
    chk("rst_seg", mode_seg, 7'b1111001);
    reset = 0;
    sc = 1; sw = 1;
    cyc(8);
    chk("ilk_up", 8'({cover_closed, water_connected}), 8'd3);
    bm = 1; cyc(2); bm = 0; cyc(2); bm = 1; cyc(10); bm = 0; cyc(8);
    chk("bounce_mode", mode, 1);
    chk("seg_mode1", mode_seg, 7'b0100100);
    press(2); press(2); press(2);
    chk("mode_seq", mode, 1);
    bs = 1; lat = -1;
    for (int i = 0; i < 10; i++) begin
      cyc(1);
      if (start === 1'b1 && lat < 0) lat = i;
    end
    chk("start_lat", 8'(lat), 8'd6);
    bs = 0; cyc(8);
    press(0); press(2);
    chk("run_hold", 8'({start, run_led, mode}), 8'b1101);
    sw = 0; cyc(12);
    chk("water_pause", 8'({start, pause}), 8'b01);
    rc = 0; bs = 1;
    for (int i = 0; i < 8; i++) begin cyc(1); rc += int'(reject); end
    bs = 0;
    for (int i = 0; i < 8; i++) begin cyc(1); rc += int'(reject); end
    chk("rej_cnt", 8'(rc), 8'd1);
    chk("rej_stay", pause, 1);
    sw = 1; cyc(8);
    press(0);
    chk("resume", start, 1);
    sc = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (cover_closed === 1'b0) break;
    end
    chk("cover_fall", cover_closed, 0);
    done = 1; cyc(1); done = 0;
    chk("done_vs_loss", 8'({start, pause}), 8'b00);
    sc = 1; cyc(8);
    press(0); press(1);
    chk("pause_press", pause, 1);
    press(1);
    chk("cancel", 8'({start, pause}), 8'b00);
    press(0); press(3);
    chk("start_pause_run", 8'({start, pause}), 8'b01);
    press(0);
    bs = 1; cyc(10);
    chk("run_before_rst", start, 1);
    reset = 1; cyc(1); reset = 0;
    chk("rst_mid", 8'({start, pause, run_led, reject, mode}), 8'd0);
    chk("rst_cover", cover_closed, 0);
    cyc(20);
    chk("held_no_start", start, 0);
    bs = 0; cyc(8);
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(5) == 0) bs = !bs;
      if ($urandom_range(5) == 0) bp = !bp;
      if ($urandom_range(4) == 0) bm = !bm;
      if ($urandom_range(39) == 0) sc = !sc;
      if ($urandom_range(39) == 0) sw = !sw;
      done = !done && ($urandom_range(24) == 0);
      reset = ($urandom_range(499) == 0);
      cyc(1);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
